ftdi_fifo_bridge: RTL

//  Parametrised FT245-style parallel-FIFO host controller. Next generation of the FTDI controller.

---
 rtl/ftdi_fifo_bridge_if.sv | 42 ++++
 rtl/ftdi_fifo_bridge.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/ftdi_fifo_bridge_if.sv
// FT245-style bridge bundle: FTDI strobes/status plus the user RX/TX ready-valid streams.
// Latency: none, wires only. Backpressure: out_rx_valid/in_rx_ready and in_tx_valid/out_tx_ready.
// FTDI_BRIDGE_STATS_EN adds the out_rx_count/out_tx_count transfer counters.
interface ftdi_fifo_bridge_if #(
  parameter int DW = 8
);
  logic          in_ftdi_rxf;
  logic          in_ftdi_txe;
  logic          out_ftdi_rd;
  logic          out_ftdi_wr;
  logic          in_rx_ena;
  logic [DW-1:0] out_rx_data;
  logic          out_rx_valid;
  logic          in_rx_ready;
  logic [DW-1:0] in_tx_data;
  logic          in_tx_valid;
  logic          out_tx_ready;
`ifdef FTDI_BRIDGE_STATS_EN
  logic [15:0]   out_rx_count;
  logic [15:0]   out_tx_count;

  modport slave (
    input  in_ftdi_rxf, in_ftdi_txe, in_rx_ena, in_rx_ready, in_tx_data, in_tx_valid,
    output out_ftdi_rd, out_ftdi_wr, out_rx_data, out_rx_valid, out_tx_ready,
    output out_rx_count, out_tx_count
  );
  modport master (
    output in_ftdi_rxf, in_ftdi_txe, in_rx_ena, in_rx_ready, in_tx_data, in_tx_valid,
    input  out_ftdi_rd, out_ftdi_wr, out_rx_data, out_rx_valid, out_tx_ready,
    input  out_rx_count, out_tx_count
  );
`else
  modport slave (
    input  in_ftdi_rxf, in_ftdi_txe, in_rx_ena, in_rx_ready, in_tx_data, in_tx_valid,
    output out_ftdi_rd, out_ftdi_wr, out_rx_data, out_rx_valid, out_tx_ready
  );
  modport master (
    output in_ftdi_rxf, in_ftdi_txe, in_rx_ena, in_rx_ready, in_tx_data, in_tx_valid,
    input  out_ftdi_rd, out_ftdi_wr, out_rx_data, out_rx_valid, out_tx_ready
  );
`endif
endinterface

// File: rtl/ftdi_fifo_bridge.sv
// FT245-style parallel-FIFO host controller with RX/TX buffer FIFOs and fair RX/TX arbitration.
// Latency: read T_RD_ACTIVE+2 cycles to RX head, write T_DATA_TO_WR+T_WR_ACTIVE+2 cycles per byte.
// Backpressure: full RX FIFO blocks new FTDI reads; full TX FIFO drops pushes (out_tx_ready=0).
// Optional: FTDI_BRIDGE_STATS_EN adds out_rx_count/out_tx_count completed-transfer counters.
module ftdi_fifo_bridge #(
  parameter int DW           = 8,
  parameter int RX_DEPTH     = 16,
  parameter int TX_DEPTH     = 16,
  parameter int T_RD_ACTIVE  = 4,
  parameter int T_RD_SAMPLE  = 3,
  parameter int T_DATA_TO_WR = 2,
  parameter int T_WR_ACTIVE  = 4
) (
  input  logic                 in_clk,
  input  logic                 in_rst,
  inout  wire  [DW-1:0]        io_ftdi_data,
  ftdi_fifo_bridge_if.slave    bus
);

  localparam int T_MAX_A = (T_RD_ACTIVE > T_RD_SAMPLE) ? T_RD_ACTIVE : T_RD_SAMPLE;
  localparam int T_MAX_B = (T_DATA_TO_WR > T_WR_ACTIVE) ? T_DATA_TO_WR : T_WR_ACTIVE;
  localparam int T_MAX   = (T_MAX_A > T_MAX_B) ? T_MAX_A : T_MAX_B;
  localparam int CW      = $clog2(T_MAX + 1);
  localparam int RX_AW   = $clog2(RX_DEPTH);
  localparam int TX_AW   = $clog2(TX_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE, S_RD_STROBE, S_RD_DONE, S_WR_SETUP, S_WR_STROBE, S_WR_HOLD
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          last_wr_q, last_wr_d;   // 1 = last served direction was a write
  logic [DW-1:0] cap_q, cap_d;           // byte sampled from the bus during a read
  logic [DW-1:0] dout_q, dout_d;         // byte driven onto the bus during a write
  logic          rd_q, wr_q, oe_q;

  logic rd_req, wr_req;
  logic rx_push, tx_pop;

  // RX FIFO: extra pointer bit distinguishes full from empty
  logic [DW-1:0] rx_mem [RX_DEPTH];
  logic [RX_AW:0] rx_wptr_q, rx_rptr_q;
  logic rx_empty, rx_full, rx_do_push, rx_do_pop;

  // TX FIFO
  logic [DW-1:0] tx_mem [TX_DEPTH];
  logic [TX_AW:0] tx_wptr_q, tx_rptr_q;
  logic tx_empty, tx_full, tx_do_push, tx_do_pop;
  logic [DW-1:0] tx_head;

  assign rx_empty   = (rx_wptr_q == rx_rptr_q);
  assign rx_full    = (rx_wptr_q[RX_AW] != rx_rptr_q[RX_AW]) &&
                      (rx_wptr_q[RX_AW-1:0] == rx_rptr_q[RX_AW-1:0]);
  assign rx_do_push = rx_push & ~rx_full;
  assign rx_do_pop  = bus.in_rx_ready & ~rx_empty;

  assign tx_empty   = (tx_wptr_q == tx_rptr_q);
  assign tx_full    = (tx_wptr_q[TX_AW] != tx_rptr_q[TX_AW]) &&
                      (tx_wptr_q[TX_AW-1:0] == tx_rptr_q[TX_AW-1:0]);
  assign tx_do_push = bus.in_tx_valid & ~tx_full;
  assign tx_do_pop  = tx_pop & ~tx_empty;
  assign tx_head    = tx_mem[tx_rptr_q[TX_AW-1:0]];

  // Pin status is only acted on in IDLE; a transfer in flight always completes
  assign rd_req = bus.in_rx_ena & bus.in_ftdi_rxf & ~rx_full;
  assign wr_req = bus.in_ftdi_txe & ~tx_empty;

  // Next-state logic: arbitration in IDLE, strobe timing via the shared delay counter
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    last_wr_d = last_wr_q;
    cap_d     = cap_q;
    dout_d    = dout_q;
    rx_push   = 1'b0;
    tx_pop    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (rd_req && (!wr_req || last_wr_q)) begin
          state_d   = S_RD_STROBE;
          last_wr_d = 1'b0;
        end else if (wr_req) begin
          state_d   = S_WR_SETUP;
          last_wr_d = 1'b1;
          dout_d    = tx_head;
        end
      end
      S_RD_STROBE: begin
        if (cnt_q == CW'(T_RD_SAMPLE)) cap_d = io_ftdi_data;
        if (cnt_q == CW'(T_RD_ACTIVE - 1)) begin
          state_d = S_RD_DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_RD_DONE: begin
        rx_push = 1'b1;
        state_d = S_IDLE;
      end
      S_WR_SETUP: begin
        if (cnt_q == CW'(T_DATA_TO_WR - 1)) begin
          state_d = S_WR_STROBE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_WR_STROBE: begin
        if (cnt_q == CW'(T_WR_ACTIVE - 1)) begin
          state_d = S_WR_HOLD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_WR_HOLD: begin
        tx_pop  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State register; pin outputs are decoded from the next state so they are registered
  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      last_wr_q <= 1'b1;
      cap_q     <= '0;
      dout_q    <= '0;
      rd_q      <= 1'b0;
      wr_q      <= 1'b0;
      oe_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      last_wr_q <= last_wr_d;
      cap_q     <= cap_d;
      dout_q    <= dout_d;
      rd_q      <= (state_d == S_RD_STROBE);
      wr_q      <= (state_d == S_WR_STROBE);
      oe_q      <= (state_d == S_WR_SETUP) || (state_d == S_WR_STROBE) ||
                   (state_d == S_WR_HOLD);
    end
  end

  // RX/TX FIFO storage (contents need no reset; pointers define validity)
  always_ff @(posedge in_clk) begin
    if (rx_do_push) rx_mem[rx_wptr_q[RX_AW-1:0]] <= cap_q;
    if (tx_do_push) tx_mem[tx_wptr_q[TX_AW-1:0]] <= bus.in_tx_data;
  end

  // FIFO pointers; reset discards all buffered data
  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      rx_wptr_q <= '0;
      rx_rptr_q <= '0;
      tx_wptr_q <= '0;
      tx_rptr_q <= '0;
    end else begin
      if (rx_do_push) rx_wptr_q <= rx_wptr_q + 1'b1;
      if (rx_do_pop)  rx_rptr_q <= rx_rptr_q + 1'b1;
      if (tx_do_push) tx_wptr_q <= tx_wptr_q + 1'b1;
      if (tx_do_pop)  tx_rptr_q <= tx_rptr_q + 1'b1;
    end
  end

  assign io_ftdi_data     = oe_q ? dout_q : {DW{1'bz}};
  assign bus.out_ftdi_rd  = rd_q;
  assign bus.out_ftdi_wr  = wr_q;
  assign bus.out_rx_valid = ~rx_empty;
  assign bus.out_rx_data  = rx_empty ? '0 : rx_mem[rx_rptr_q[RX_AW-1:0]];
  assign bus.out_tx_ready = ~tx_full;

`ifdef FTDI_BRIDGE_STATS_EN
  logic [15:0] rx_cnt_q, tx_cnt_q;

  // Completed-transfer counters, wrapping naturally at 16 bits
  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      rx_cnt_q <= '0;
      tx_cnt_q <= '0;
    end else begin
      if (state_q == S_RD_DONE) rx_cnt_q <= rx_cnt_q + 16'd1;
      if (state_q == S_WR_HOLD) tx_cnt_q <= tx_cnt_q + 16'd1;
    end
  end

  assign bus.out_rx_count = rx_cnt_q;
  assign bus.out_tx_count = tx_cnt_q;
`endif

endmodule
